// File: rtl/alu_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_req_arbiter
//  Description : Round-robin arbiter sharing one multi-cycle ALU among
//                NUM_REQ requesters. Drives the ALU start/op/operand
//                interface, waits for done (or times out) and returns the
//                result tagged with the granted requester index.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [3*NUM_REQ-1:0]       req_op,
    input  logic [8*NUM_REQ-1:0]       req_a,
    input  logic [8*NUM_REQ-1:0]       req_b,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [15:0]                rsp_result,
    output logic                       rsp_err,
    output logic                       busy,
    output logic                       alu_start,
    output logic [2:0]                 alu_op,
    output logic [7:0]                 alu_a,
    output logic [7:0]                 alu_b,
    input  logic                       alu_done,
    input  logic [15:0]                alu_result
);

    localparam int c_ID_W  = $clog2(NUM_REQ);
    localparam int c_SUM_W = c_ID_W + 1;
    localparam int c_CNT_W = $clog2(TIMEOUT);

    localparam logic [2:0] c_OP_NOP = 3'b000;
    localparam logic [2:0] c_OP_MAX = 3'b100;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_ID_W-1:0]   r_ptr;
    logic [c_CNT_W-1:0]  r_cnt;

    logic                w_found;
    logic [c_ID_W-1:0]   w_win;
    logic [2:0]          w_op;
    logic [7:0]          w_a;
    logic [7:0]          w_b;
    logic [c_SUM_W-1:0]  w_sum;
    logic [c_ID_W-1:0]   w_cand;
    logic [c_ID_W-1:0]   w_ptr_nxt;

    // Round-robin search starting at the pointer; first asserted request wins
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_op    = '0;
        w_a     = '0;
        w_b     = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_ptr} + c_SUM_W'(i);
            if (w_sum >= c_SUM_W'(NUM_REQ)) begin
                w_sum = w_sum - c_SUM_W'(NUM_REQ);
            end
            w_cand = w_sum[c_ID_W-1:0];
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_found && (w_win == c_ID_W'(j))) begin
                w_op = req_op[3*j +: 3];
                w_a  = req_a[8*j +: 8];
                w_b  = req_b[8*j +: 8];
            end
        end
        w_ptr_nxt = (w_win == c_ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
    end

    // Control FSM with all outputs registered; reset aborts any operation silently
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_cnt      <= '0;
            gnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            alu_start  <= 1'b0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
        end else begin
            gnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        gnt[w_win] <= 1'b1;
                        rsp_id     <= w_win;
                        alu_op     <= w_op;
                        alu_a      <= w_a;
                        alu_b      <= w_b;
                        r_ptr      <= w_ptr_nxt;
                        if (w_op > c_OP_MAX) begin
                            // Illegal op: answer immediately, ALU never started
                            rsp_valid  <= 1'b1;
                            rsp_err    <= 1'b1;
                            rsp_result <= '0;
                        end else begin
                            alu_start <= 1'b1;
                            busy      <= 1'b1;
                            r_cnt     <= '0;
                            r_state   <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (alu_op == c_OP_NOP) begin
                        // The ALU never signals done for no_op
                        alu_start  <= 1'b0;
                        busy       <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_result <= '0;
                        r_state    <= S_IDLE;
                    end else if (alu_done) begin
                        alu_start  <= 1'b0;
                        busy       <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_result <= alu_result;
                        r_state    <= S_IDLE;
                    end else if (r_cnt == c_CNT_W'(TIMEOUT - 1)) begin
                        alu_start  <= 1'b0;
                        busy       <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_err    <= 1'b1;
                        rsp_result <= '0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_alu_req_arbiter
//  Description : Directed self-checking bench for alu_req_arbiter with a
//                behavioural ALU and grant/response scoreboards.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_req_arbiter;

    localparam int N        = 4;
    localparam int TO       = 16;
    localparam int DONE_LAT = 3;

    logic            clk;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [3*N-1:0]  req_op;
    logic [8*N-1:0]  req_a;
    logic [8*N-1:0]  req_b;
    logic [N-1:0]    gnt;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [15:0]     rsp_result;
    logic            rsp_err;
    logic            busy;
    logic            alu_start;
    logic [2:0]      alu_op;
    logic [7:0]      alu_a;
    logic [7:0]      alu_b;
    logic            alu_done   = 1'b0;
    logic [15:0]     alu_result = 16'h0;

    int              checks   = 0;
    int              failures = 0;
    logic            hang     = 1'b0;
    int              m_cnt    = 0;
    int              m_gid;
    logic [18:0]     m_rsp;

    int              exp_gnt_q[$];
    logic [18:0]     exp_rsp_q[$];

    alu_req_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd1:    return {8'h0, a} + {8'h0, b};
            3'd2:    return {8'h0, a & b};
            3'd3:    return {8'h0, a ^ b};
            3'd4:    return {8'h0, a} * {8'h0, b};
            default: return 16'h0;
        endcase
    endfunction

    // Behavioural ALU: done pulses DONE_LAT cycles after start is first seen
    always @(posedge clk) begin
        alu_done <= 1'b0;
        if (alu_start && alu_op != 3'd0 && !hang) begin
            if (m_cnt == DONE_LAT - 1) begin
                alu_done   <= 1'b1;
                alu_result <= alu_ref(alu_op, alu_a, alu_b);
                m_cnt      <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else begin
            m_cnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every grant and response must match the next expectation
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (gnt !== '0) begin
                if (exp_gnt_q.size() == 0) begin
                    chk("gnt_unexpected", 64'(gnt), 64'd0);
                end else begin
                    m_gid = exp_gnt_q.pop_front();
                    chk("gnt_order", 64'(gnt), 64'(1 << m_gid));
                end
            end
            if (rsp_valid === 1'b1) begin
                if (exp_rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    m_rsp = exp_rsp_q.pop_front();
                    chk("rsp_fields", 64'({rsp_id, rsp_err, rsp_result}), 64'(m_rsp));
                end
            end
        end
    end

    task automatic set_fields(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[3*id +: 3] = op;
        req_a[8*id +: 8]  = a;
        req_b[8*id +: 8]  = b;
    endtask

    task automatic push(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic        err;
        logic [15:0] res;
        err = (op > 3'd4) || (hang && op != 3'd0);
        res = err ? 16'h0 : alu_ref(op, a, b);
        exp_gnt_q.push_back(id);
        exp_rsp_q.push_back({2'(id), err, res});
    endtask

    function automatic logic [44:0] all_outs();
        return {gnt, rsp_valid, rsp_id, rsp_result, rsp_err, busy, alu_start, alu_op, alu_a, alu_b};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'(all_outs()), 64'd0);
        reset_n = 1'b1;
    endtask

    // Single request: counts alu_start-high cycles up to the response
    task automatic issue(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int exp_start);
        int sc;
        bit got;
        sc  = 0;
        got = 1'b0;
        push(id, op, a, b);
        set_fields(id, op, a, b);
        req[id] = 1'b1;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (gnt[id]) begin
                req[id] = 1'b0;
                chk("start_with_gnt", 64'(alu_start), 64'(op <= 3'd4));
            end
            if (rsp_valid) begin
                got = 1'b1;
                chk("gnt_with_rsp", 64'(gnt[id]), 64'(op > 3'd4));
                chk("busy_after_rsp", 64'(busy), 64'd0);
                chk("start_after_rsp", 64'(alu_start), 64'd0);
            end else if (alu_start) begin
                sc++;
            end
        end
        chk("rsp_seen", 64'(got), 64'd1);
        chk("start_cycles", 64'(sc), 64'(exp_start));
        @(negedge clk);
    endtask

    // Multiple held requests: drop each as it is granted, wait for n responses
    task automatic batch(input int n);
        int cnt;
        cnt = 0;
        for (int t = 0; t < 300 && cnt < n; t++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (gnt[k]) req[k] = 1'b0;
            end
            if (rsp_valid) cnt++;
        end
        chk("batch_rsp_count", 64'(cnt), 64'(n));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit gseen;
        reset_n = 1'b0;
        req     = '0;
        req_op  = '0;
        req_a   = '0;
        req_b   = '0;
        @(negedge clk);
        do_reset();

        // Round-robin with all four requesting mul
        for (int i = 0; i < N; i++) begin
            set_fields(i, 3'd4, 8'(i + 3), 8'(10 * i + 5));
            push(i, 3'd4, 8'(i + 3), 8'(10 * i + 5));
        end
        req = 4'b1111;
        batch(4);

        // Pointer back at 0: requester 0 then 2
        set_fields(0, 3'd1, 8'd20, 8'd30);
        set_fields(2, 3'd3, 8'hA5, 8'h0F);
        push(0, 3'd1, 8'd20, 8'd30);
        push(2, 3'd3, 8'hA5, 8'h0F);
        req = 4'b0101;
        batch(2);

        // Single add
        issue(0, 3'd1, 8'd100, 8'd55, DONE_LAT + 1);
        chk("operands_held", 64'({alu_op, alu_a, alu_b}), 64'({3'd1, 8'd100, 8'd55}));

        // no_op: start for exactly one cycle
        issue(1, 3'd0, 8'd9, 8'd9, 1);

        // Illegal op: immediate error response, no start
        issue(3, 3'd6, 8'd1, 8'd2, 0);

        // Timeout: ALU never answers
        hang = 1'b1;
        issue(2, 3'd3, 8'h3C, 8'hC3, TO);
        hang = 1'b0;

        // Reset in the middle of a mul
        set_fields(1, 3'd4, 8'd7, 8'd9);
        exp_gnt_q.push_back(1);
        req[1] = 1'b1;
        gseen  = 1'b0;
        for (int t = 0; t < 20 && !gseen; t++) begin
            @(negedge clk);
            if (gnt[1]) gseen = 1'b1;
        end
        req[1] = 1'b0;
        chk("mid_run_gnt_seen", 64'(gseen), 64'd1);
        repeat (2) @(negedge clk);
        chk("mid_run_busy", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1 chk("async_reset_outputs", 64'(all_outs()), 64'd0);
        repeat (2) @(negedge clk);
        chk("held_reset_outputs", 64'(all_outs()), 64'd0);
        set_fields(1, 3'd1, 8'd11, 8'd22);
        set_fields(2, 3'd2, 8'hF0, 8'h3C);
        push(1, 3'd1, 8'd11, 8'd22);
        push(2, 3'd2, 8'hF0, 8'h3C);
        req     = 4'b0110;
        reset_n = 1'b1;
        batch(2);

        chk("gnt_queue_drained", 64'(exp_gnt_q.size()), 64'd0);
        chk("rsp_queue_drained", 64'(exp_rsp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
